// File: rtl/av_sched_pkg.sv
// rtl/av_sched_pkg.sv - shared types and precision codes for the attention AV scheduler
//
// Purpose : scheduler state encoding and token-precision codes.
//           The precision codes are shared with the attention_av_multiply engine
//           and its testbench.
// Ports   : none (package)
package av_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam logic [3:0] PREC_INT4 = 4'd0;
    localparam logic [3:0] PREC_INT8 = 4'd1;
    localparam logic [3:0] PREC_FP16 = 4'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority requester pick
//
// Purpose : picks the first set request bit, searching upward from
//           last_grant+1 and wrapping modulo NUM_REQ.
// Ports   : req        - request vector, one bit per requester
//           last_grant - index of the most recently served requester
//           gnt_idx    - selected requester index (valid when gnt_any)
//           gnt_any    - at least one request is set
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);

    localparam int IW = $clog2(NUM_REQ);

    int k;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // last_grant is the one left standing.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = (int'(last_grant) + i) % NUM_REQ;
            if (req[IW'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/attention_av_scheduler.sv
// rtl/attention_av_scheduler.sv - round-robin job scheduler for one shared attention_av_multiply engine
//
// Purpose : arbitrates NUM_REQ requesters, snapshots the granted requester's
//           token-precision row, runs the engine start/done handshake with a
//           timeout, and returns a tagged completion.
// Ports   : clk, rst_n                  - clock, asynchronous active-low reset
//           req_valid / req_accept      - level requests / one-cycle one-hot accept
//           cfg_we, cfg_id, cfg_tok,
//           cfg_prec                    - precision-table write port
//           eng_start / eng_done        - engine handshake
//           eng_token_precision         - precision snapshot for the running job
//           eng_sel                     - granted requester, steers external muxes
//           rsp_valid, rsp_id,
//           rsp_timeout / rsp_ready     - completion handshake
//           busy                        - any state other than IDLE
module attention_av_scheduler
    import av_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int L       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_accept,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0] cfg_id,
    input  logic [$clog2(L)-1:0]       cfg_tok,
    input  logic [3:0]                 cfg_prec,
    output logic                       eng_start,
    input  logic                       eng_done,
    output logic [L-1:0][3:0]          eng_token_precision,
    output logic [$clog2(NUM_REQ)-1:0] eng_sel,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_timeout,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_t                    state_q, state_d;
    logic [IW-1:0]                   last_grant_q;
    logic [IW-1:0]                   gnt_idx;
    logic                            gnt_any;
    logic [CW-1:0]                   cnt_q;
    logic [NUM_REQ-1:0][L-1:0][3:0]  prec_tbl_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is checked before the terminal count so a done arriving on the
    // last counted cycle completes normally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (gnt_any) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (eng_done || (cnt_q == CNT_LAST)) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_accept = '0;
        eng_start  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE:  if (gnt_any) req_accept[gnt_idx] = 1'b1;
            ST_START: eng_start = 1'b1;
            ST_RESP:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign rsp_id = eng_sel;

    // Job context. eng_sel and the snapshot only change on a grant so the
    // external muxes stay valid through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q        <= IW'(NUM_REQ - 1);
            eng_sel             <= '0;
            eng_token_precision <= {L{PREC_FP16}};
            cnt_q               <= '0;
            rsp_timeout         <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        eng_sel             <= gnt_idx;
                        eng_token_precision <= prec_tbl_q[gnt_idx];
                    end
                end
                ST_START: begin
                    cnt_q       <= '0;
                    rsp_timeout <= 1'b0;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        rsp_timeout <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) last_grant_q <= eng_sel;
                end
                default: ;
            endcase
        end
    end

    // Table write and snapshot read share a cycle; the snapshot sees the
    // pre-write value because both are registered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prec_tbl_q <= {(NUM_REQ * L){PREC_FP16}};
        end else if (cfg_we) begin
            prec_tbl_q[cfg_id][cfg_tok] <= cfg_prec;
        end
    end

endmodule

// File: tb/tb_attention_av_scheduler.sv
// tb/tb_attention_av_scheduler.sv - directed self-checking bench for attention_av_scheduler
module tb_attention_av_scheduler;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_accept;
    logic             cfg_we;
    logic [1:0]       cfg_id;
    logic [2:0]       cfg_tok;
    logic [3:0]       cfg_prec;
    logic             eng_start;
    logic             eng_done;
    logic [7:0][3:0]  eng_token_precision;
    logic [1:0]       eng_sel;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic             rsp_timeout;
    logic             rsp_ready;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    attention_av_scheduler #(
        .NUM_REQ (4),
        .L       (8),
        .TIMEOUT (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_accept          (req_accept),
        .cfg_we              (cfg_we),
        .cfg_id              (cfg_id),
        .cfg_tok             (cfg_tok),
        .cfg_prec            (cfg_prec),
        .eng_start           (eng_start),
        .eng_done            (eng_done),
        .eng_token_precision (eng_token_precision),
        .eng_sel             (eng_sel),
        .rsp_valid           (rsp_valid),
        .rsp_id              (rsp_id),
        .rsp_timeout         (rsp_timeout),
        .rsp_ready           (rsp_ready),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] id, input logic [2:0] tok, input logic [3:0] prec);
        cfg_we   = 1'b1;
        cfg_id   = id;
        cfg_tok  = tok;
        cfg_prec = prec;
        tick();
        cfg_we   = 1'b0;
    endtask

    // done_dly > 0: eng_done pulses done_dly cycles after the START cycle.
    // done_dly <= 0: no done; the timeout path is measured from WAIT entry.
    // stall: cycles of rsp_ready=0 in RESP, with a stray eng_done driven.
    task automatic do_job(input logic [3:0] rv, input int done_dly, input int stall,
                          input logic exp_to, input int exp_gnt);
        int waited;
        logic [1:0] sel0;
        req_valid = rv;
        #1;
        waited = 0;
        while (req_accept == 4'b0 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            chk("accept_wait", 64'(waited), 64'(0));
            return;
        end
        chk("accept", 64'(req_accept), 64'(1) << exp_gnt);
        tick();
        chk("start", 64'(eng_start), 64'(1));
        chk("sel", 64'(eng_sel), 64'(exp_gnt));
        chk("accept_in_start", 64'(req_accept), 64'(0));
        tick();
        chk("start_one_cycle", 64'(eng_start), 64'(0));
        if (done_dly > 0) begin
            repeat (done_dly - 1) tick();
            chk("early_rsp", 64'(rsp_valid), 64'(0));
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
        end else begin
            waited = 0;
            while (!rsp_valid && waited < 40) begin
                tick();
                waited++;
            end
            chk("timeout_latency", 64'(waited), 64'(16));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(exp_gnt));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        sel0 = eng_sel;
        if (stall > 0) begin
            rsp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                eng_done = 1'b1;
                tick();
                chk("stall_valid", 64'(rsp_valid), 64'(1));
                chk("stall_id", 64'(rsp_id), 64'(exp_gnt));
                chk("stall_sel", 64'(eng_sel), 64'(sel0));
                chk("stall_to", 64'(rsp_timeout), 64'(exp_to));
                chk("stall_accept", 64'(req_accept), 64'(0));
            end
            eng_done  = 1'b0;
            rsp_ready = 1'b1;
        end
        tick();
        chk("idle_after_rsp", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        cfg_we    = 1'b0;
        cfg_id    = '0;
        cfg_tok   = '0;
        cfg_prec  = '0;
        eng_done  = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_eng_start", 64'(eng_start), 64'(0));
        chk("rst_accept", 64'(req_accept), 64'(0));
        chk("rst_sel", 64'(eng_sel), 64'(0));
        chk("rst_to", 64'(rsp_timeout), 64'(0));
        chk("rst_prec", 64'(eng_token_precision), 64'h2222_2222);

        do_job(4'b0001, 3, 0, 1'b0, 0);
        req_valid = '0;
        chk("default_prec", 64'(eng_token_precision), 64'h2222_2222);

        cfg_write(2'd2, 3'd3, 4'd0);
        cfg_write(2'd2, 3'd5, 4'd1);
        do_job(4'b0100, 11, 0, 1'b0, 2);
        req_valid = '0;
        chk("cfg_prec_row2", 64'(eng_token_precision), 64'h2212_0222);
        chk("cfg_prec_tok3", 64'(eng_token_precision[3]), 64'(0));
        chk("cfg_prec_tok5", 64'(eng_token_precision[5]), 64'(1));

        do_job(4'b1111, 1, 0, 1'b0, 3);
        do_job(4'b1111, 1, 0, 1'b0, 0);
        do_job(4'b1111, 2, 0, 1'b0, 1);
        do_job(4'b1111, 1, 0, 1'b0, 2);
        do_job(4'b1111, 1, 0, 1'b0, 3);
        do_job(4'b1010, 1, 0, 1'b0, 1);
        do_job(4'b1010, 1, 0, 1'b0, 3);
        do_job(4'b1010, 1, 0, 1'b0, 1);
        do_job(4'b1010, 1, 0, 1'b0, 3);

        do_job(4'b1111, 2, 5, 1'b0, 0);
        chk("bp_next_grant", 64'(req_accept), 64'b0010);
        do_job(4'b1111, 1, 0, 1'b0, 1);
        req_valid = '0;

        do_job(4'b0001, 0, 3, 1'b1, 0);
        req_valid = '0;
        eng_done  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("late_done_rsp", 64'(rsp_valid), 64'(0));
            chk("late_done_busy", 64'(busy), 64'(0));
        end
        eng_done = 1'b0;

        do_job(4'b1000, 16, 0, 1'b0, 3);
        req_valid = '0;

        req_valid = 4'b0010;
        cfg_we    = 1'b1;
        cfg_id    = 2'd1;
        cfg_tok   = 3'd0;
        cfg_prec  = 4'd0;
        #1;
        chk("grant_cycle_accept", 64'(req_accept), 64'b0010);
        tick();
        cfg_we    = 1'b0;
        req_valid = '0;
        chk("grant_cycle_snapshot", 64'(eng_token_precision), 64'h2222_2222);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("grant_cycle_rsp", 64'(rsp_valid), 64'(1));
        tick();
        do_job(4'b0010, 1, 0, 1'b0, 1);
        req_valid = '0;
        chk("new_snapshot", 64'(eng_token_precision), 64'h2222_2220);
        cfg_write(2'd1, 3'd1, 4'd0);
        chk("idle_write_no_snap", 64'(eng_token_precision), 64'h2222_2220);

        req_valid = 4'b0100;
        #1;
        chk("pre_rst_accept", 64'(req_accept), 64'b0100);
        tick();
        req_valid = '0;
        tick();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_sel", 64'(eng_sel), 64'(0));
        chk("mid_rst_prec", 64'(eng_token_precision), 64'h2222_2222);
        tick();
        rst_n = 1'b1;
        #1;
        do_job(4'b1111, 1, 0, 1'b0, 0);
        do_job(4'b0100, 1, 0, 1'b0, 2);
        req_valid = '0;
        chk("post_rst_table", 64'(eng_token_precision), 64'h2222_2222);
        do_job(4'b0010, 1, 0, 1'b0, 1);
        req_valid = '0;
        chk("post_rst_row1", 64'(eng_token_precision), 64'h2222_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
